// File: rtl/tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tag_fifo
// Description : Free-tag allocator for the rename stage. Keeps the pool of
//               unused rename tags in a circular FIFO. Dispatch pops one tag
//               per instruction, commit pushes retired tags back, and flush
//               returns every tag to the pool.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous reset, active-low
//   alloc_ren     in   1        dispatch pops the head tag this cycle
//   alloc_tag     out  TAG_W    head tag (first-word fall-through)
//   alloc_empty   out  1        no free tag available
//   free_wen      in   1        commit returns free_tag this cycle
//   free_tag      in   TAG_W    tag being returned
//   flush         in   1        synchronous: return all tags to the pool
//   count         out  TAG_W+1  number of free tags held, 0..DEPTH
//   full          out  1        count == DEPTH
//   overflow_err  out  1        sticky: push while full with no pop
//   underflow_err out  1        sticky: pop while empty
// ============================================================================
module tag_fifo #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 64   // must equal 2**TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_ren,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_empty,
    input  logic             free_wen,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             flush,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [TAG_W:0]   c_full_cnt = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   c_cnt_one  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] c_ptr_one  = TAG_W'(1);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [TAG_W-1:0] r_rd_ptr;
    logic [TAG_W-1:0] r_wr_ptr;
    logic [TAG_W:0]   r_count;
    logic             r_overflow_err;
    logic             r_underflow_err;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    // Status flags are decoded from the registered count, so they never
    // reflect a same-cycle push (no bypass into an empty FIFO).
    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // A push is allowed at full when a pop frees the slot in the same cycle.
    assign w_pop  = alloc_ren & ~w_empty;
    assign w_push = free_wen & (~w_full | w_pop);

    // Storage, pointers and count. Reset and flush both reload the identity
    // pool mem[i]=i; flush takes priority over any same-cycle pop or push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_W'(i);
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= c_full_cnt;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_W'(i);
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= c_full_cnt;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= free_tag;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (free_wen && w_full && !w_pop) begin
                r_overflow_err <= 1'b1;
            end
            if (alloc_ren && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign alloc_tag     = r_mem[r_rd_ptr];
    assign alloc_empty   = w_empty;
    assign count         = r_count;
    assign full          = w_full;
    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;

endmodule
`default_nettype wire

// File: tb/tb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_fifo
// Description : Directed self-checking bench for tag_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_fifo;

    localparam int TAG_W = 6;
    localparam int DEPTH = 64;

    logic             clk;
    logic             reset;
    logic             alloc_ren;
    logic [TAG_W-1:0] alloc_tag;
    logic             alloc_empty;
    logic             free_wen;
    logic [TAG_W-1:0] free_tag;
    logic             flush;
    logic [TAG_W:0]   count;
    logic             full;
    logic             overflow_err;
    logic             underflow_err;

    int checks;
    int errors;

    tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_ren     (alloc_ren),
        .alloc_tag     (alloc_tag),
        .alloc_empty   (alloc_empty),
        .free_wen      (free_wen),
        .free_tag      (free_tag),
        .flush         (flush),
        .count         (count),
        .full          (full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        alloc_ren = 1'b0;
        free_wen  = 1'b0;
        free_tag  = '0;
        flush     = 1'b0;
        #1 reset  = 1'b0;
        tick();
        tick();

        // 1: state while in reset, then after release
        chk("rst_full",      full,        1);
        chk("rst_empty",     alloc_empty, 0);
        chk("rst_tag",       alloc_tag,   0);
        chk("rst_count",     count,       64);
        reset = 1'b1;
        tick();
        chk("init_tag",      alloc_tag,     0);
        chk("init_count",    count,         64);
        chk("init_full",     full,          1);
        chk("init_empty",    alloc_empty,   0);
        chk("init_ovf",      overflow_err,  0);
        chk("init_unf",      underflow_err, 0);

        // 2: three pops take tags 0,1,2
        alloc_ren = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("pop3_tag", alloc_tag, k);
            tick();
        end
        alloc_ren = 1'b0;
        chk("pop3_next_tag", alloc_tag, 3);
        chk("pop3_count",    count,     61);
        chk("pop3_full",     full,      0);

        // 3: drain the remaining 61 tags, then one pop too many
        alloc_ren = 1'b1;
        for (int k = 3; k < 64; k++) begin
            chk("drain_tag", alloc_tag, k);
            tick();
        end
        alloc_ren = 1'b0;
        chk("drain_empty", alloc_empty,   1);
        chk("drain_count", count,         0);
        chk("drain_unf0",  underflow_err, 0);
        alloc_ren = 1'b1;
        tick();
        alloc_ren = 1'b0;
        chk("unf_flag",  underflow_err, 1);
        chk("unf_count", count,         0);

        // 4: push into empty; not visible until the next cycle
        free_wen = 1'b1;
        free_tag = 6'd5;
        chk("push_empty_same", alloc_empty, 1);
        tick();
        free_wen = 1'b0;
        chk("push_empty_tag",   alloc_tag,   5);
        chk("push_empty_count", count,       1);
        chk("push_empty_flag",  alloc_empty, 0);

        // 5: refill via flush; flush keeps the sticky underflow flag
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", count,         64);
        chk("flush_tag",   alloc_tag,     0);
        chk("flush_unf",   underflow_err, 1);

        // simultaneous push+pop at full: tag 0 out, tag 9 into slot 0
        free_wen  = 1'b1;
        free_tag  = 6'd9;
        alloc_ren = 1'b1;
        tick();
        free_wen  = 1'b0;
        chk("pp_count", count,        64);
        chk("pp_ovf",   overflow_err, 0);
        chk("pp_tag",   alloc_tag,    1);
        for (int k = 1; k < 64; k++) begin
            tick();
        end
        alloc_ren = 1'b0;
        chk("wrap_tag",   alloc_tag, 9);
        chk("wrap_count", count,     1);

        // full again; a lone push is dropped and flags overflow
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        free_wen = 1'b1;
        free_tag = 6'd33;
        tick();
        free_wen = 1'b0;
        chk("ovf_flag",  overflow_err, 1);
        chk("ovf_count", count,        64);
        chk("ovf_tag",   alloc_tag,    0);

        // 6: ten pops, then flush together with a pop
        alloc_ren = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        chk("pop10_tag",   alloc_tag, 10);
        chk("pop10_count", count,     54);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        alloc_ren = 1'b0;
        chk("flushpop_count", count,         64);
        chk("flushpop_tag",   alloc_tag,     0);
        chk("flushpop_ovf",   overflow_err,  1);

        // ordinary push into a partially drained pool
        alloc_ren = 1'b1;
        tick();
        tick();
        alloc_ren = 1'b0;
        free_wen  = 1'b1;
        free_tag  = 6'd40;
        tick();
        free_wen  = 1'b0;
        chk("mid_push_count", count,     63);
        chk("mid_push_tag",   alloc_tag, 2);

        // async reset mid-stream, checked without any clock edge
        alloc_ren = 1'b1;
        tick();
        tick();
        alloc_ren = 1'b0;
        chk("pre_arst_tag", alloc_tag, 4);
        reset = 1'b0;
        #2;
        chk("arst_count", count,         64);
        chk("arst_tag",   alloc_tag,     0);
        chk("arst_full",  full,          1);
        chk("arst_ovf",   overflow_err,  0);
        chk("arst_unf",   underflow_err, 0);
        reset = 1'b1;
        tick();
        chk("post_arst_tag",   alloc_tag, 0);
        chk("post_arst_count", count,     64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
